// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory subsystem: word RAM, keyboard/display MMIO, MEM_EN/R
// handshake with WAIT_STATES programmable latency.
//
// Ports:
//   i_Clk, i_Rst_n            clock, async active-low reset
//   MEM_EN, RW                request strobe (held until R), 1 = write
//   MAR_OUT, MDR_OUT          access address, write data
//   OUT, R                    registered read data, access complete
//   i_Kbd_Valid, i_Kbd_Data   keyboard key pulse and code
//   o_Kbd_Int                 KBSR ready & IE
//   o_Dsp_Valid, o_Dsp_Data   pending display character
//   i_Dsp_Ready               display accepts character
//   o_Dsp_Int                 DSR ready & IE
//   o_Err                     sticky unmapped-access flag
//
// Optional feature: define LC3_MEM_BOUNDS_ERR_EN to make o_Err latch
// on any completed access to an unmapped address (else tied 0).

module lc3_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 32768,
    parameter int WAIT_STATES = 1,
    parameter int MMIO_BASE   = 'hFE00
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              MEM_EN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] MAR_OUT,
    input  logic [DATA_W-1:0] MDR_OUT,
    output logic [DATA_W-1:0] OUT,
    output logic              R,
    input  logic              i_Kbd_Valid,
    input  logic [7:0]        i_Kbd_Data,
    output logic              o_Kbd_Int,
    output logic              o_Dsp_Valid,
    output logic [7:0]        o_Dsp_Data,
    input  logic              i_Dsp_Ready,
    output logic              o_Dsp_Int,
    output logic              o_Err
);

    localparam int RA_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] A_TOP  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] A_KBSR = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] A_KBDR = ADDR_W'(MMIO_BASE + 2);
    localparam logic [ADDR_W-1:0] A_DSR  = ADDR_W'(MMIO_BASE + 4);
    localparam logic [ADDR_W-1:0] A_DDR  = ADDR_W'(MMIO_BASE + 6);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;
    logic              do_acc;

    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_rw;
    logic [RA_W-1:0]   ridx;

    logic in_ram;
    logic is_kbsr;
    logic is_kbdr;
    logic is_dsr;
    logic is_ddr;
    logic wr;
    logic rd;
    logic kbdr_rd;
    logic kb_cap;

    logic [DATA_W-1:0] rd_data;

    logic       kb_rdy;
    logic       kb_ie;
    logic [7:0] kb_data;
    logic       ds_ie;
    logic       dsp_valid;
    logic [7:0] dsp_data;

    logic [DATA_W-1:0] ram [DEPTH];

    // With zero wait states the access completes on the sampling
    // edge, so the live bus is used instead of the latched copy.
    assign acc_addr = (state == S_IDLE) ? MAR_OUT : addr_q;
    assign acc_data = (state == S_IDLE) ? MDR_OUT : data_q;
    assign acc_rw   = (state == S_IDLE) ? RW      : rw_q;
    assign ridx     = acc_addr[RA_W-1:0];

    assign in_ram  = (acc_addr < A_TOP);
    assign is_kbsr = (acc_addr == A_KBSR);
    assign is_kbdr = (acc_addr == A_KBDR);
    assign is_dsr  = (acc_addr == A_DSR);
    assign is_ddr  = (acc_addr == A_DDR);

    assign wr      = do_acc & acc_rw;
    assign rd      = do_acc & ~acc_rw;
    assign kbdr_rd = rd & is_kbdr;

    // A KBDR read frees the buffer on the same edge, so a key
    // arriving then is still accepted.
    assign kb_cap = i_Kbd_Valid & (~kb_rdy | kbdr_rd);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_acc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MEM_EN) begin
                    cnt_nxt = WS;
                    if (WS == 4'd0) begin
                        do_acc    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!MEM_EN) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    do_acc    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (!MEM_EN) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            in_ram: rd_data = ram[ridx];
            is_kbsr: begin
                rd_data[DATA_W-1] = kb_rdy;
                rd_data[DATA_W-2] = kb_ie;
            end
            is_kbdr: rd_data[7:0] = kb_data;
            is_dsr: begin
                rd_data[DATA_W-1] = ~dsp_valid;
                rd_data[DATA_W-2] = ds_ie;
            end
            is_ddr: rd_data[7:0] = dsp_data;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && MEM_EN) begin
                addr_q <= MAR_OUT;
                data_q <= MDR_OUT;
                rw_q   <= RW;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            OUT       <= '0;
            kb_rdy    <= 1'b0;
            kb_ie     <= 1'b0;
            kb_data   <= '0;
            ds_ie     <= 1'b0;
            dsp_valid <= 1'b0;
            dsp_data  <= '0;
        end else begin
            if (rd) begin
                OUT <= rd_data;
            end
            if (kb_cap) begin
                kb_data <= i_Kbd_Data;
                kb_rdy  <= 1'b1;
            end else if (kbdr_rd) begin
                kb_rdy <= 1'b0;
            end
            if (wr && is_kbsr) begin
                kb_ie <= acc_data[DATA_W-2];
            end
            if (wr && is_dsr) begin
                ds_ie <= acc_data[DATA_W-2];
            end
            // A DDR write is only accepted while the display is
            // idle, so it never collides with the handshake clear.
            if (dsp_valid && i_Dsp_Ready) begin
                dsp_valid <= 1'b0;
            end else if (wr && is_ddr && !dsp_valid) begin
                dsp_valid <= 1'b1;
                dsp_data  <= acc_data[7:0];
            end
        end
    end

    // RAM is not reset; the reset gate stops a write from landing
    // while reset is held.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_n && wr && in_ram) begin
            ram[ridx] <= acc_data;
        end
    end

`ifdef LC3_MEM_BOUNDS_ERR_EN
    logic err_q;
    logic unmapped;

    assign unmapped = ~(in_ram | is_kbsr | is_kbdr | is_dsr | is_ddr);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            err_q <= 1'b0;
        end else if (do_acc && unmapped) begin
            err_q <= 1'b1;
        end
    end

    assign o_Err = err_q;
`else
    assign o_Err = 1'b0;
`endif

    assign R           = (state == S_DONE);
    assign o_Kbd_Int   = kb_rdy & kb_ie;
    assign o_Dsp_Valid = dsp_valid;
    assign o_Dsp_Data  = dsp_data;
    assign o_Dsp_Int   = ~dsp_valid & ds_ie;

endmodule
